// File: rtl/fpu_op_dispatcher.sv
// fpu_op_dispatcher
// Command front-end for FPU_Interface2. Commands (opcode, angle region,
// two operands) are queued in a small FIFO and issued one at a time using
// the FPU begin/ready/ack handshake. Each result and its flags are captured
// and offered on a valid/ready result port.
//
// Optional feature: define FPU_DISPATCH_TIMEOUT_EN to bound the wait for
// fpu_operation_ready to TIMEOUT cycles. A timed-out operation completes
// with res_data = 0 and res_flags = 4'b1000. Without the macro the wait is
// unbounded and res_flags[3] is always 0.
module fpu_op_dispatcher #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  // command port
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_operation,
  input  logic [1:0]   cmd_region,
  input  logic [W-1:0] cmd_data_1,
  input  logic [W-1:0] cmd_data_2,
  input  logic [1:0]   r_mode_in,
  // FPU side
  output logic         fpu_begin_operation,
  output logic         fpu_ack_operation,
  output logic [2:0]   fpu_operation,
  output logic [1:0]   fpu_region_flag,
  output logic [W-1:0] fpu_data_1,
  output logic [W-1:0] fpu_data_2,
  output logic [1:0]   fpu_r_mode,
  input  logic         fpu_operation_ready,
  input  logic [W-1:0] fpu_op_result,
  input  logic         fpu_overflow_flag,
  input  logic         fpu_underflow_flag,
  input  logic         fpu_NaN_flag,
  // result port
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [3:0]   res_flags
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // One FIFO entry: {operation, region, data_1, data_2}
  localparam int EW = 5 + 2 * W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [EW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    rg_q, rg_d;
  logic [W-1:0]  d1_q, d1_d;
  logic [W-1:0]  d2_q, d2_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [3:0]    res_flags_q, res_flags_d;

  logic          push, pop;
  logic          fifo_empty;
  logic [EW-1:0] head;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign cmd_ready  = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid & cmd_ready;
  assign head       = fifo_q[rd_ptr_q];

  // FIFO storage: payload only, no reset needed since count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cmd_operation, cmd_region, cmd_data_1, cmd_data_2};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps count
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic: issue, wait for ready, drain ready through ACK, offer result
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rg_d        = rg_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    pop         = 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          {op_d, rg_d, d1_d, d2_d} = head;
          pop     = 1'b1;
          state_d = S_WAIT;
`ifdef FPU_DISPATCH_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (fpu_operation_ready) begin
          // Result is taken on the very first ready cycle only
          res_data_d  = fpu_op_result;
          res_flags_d = {1'b0, fpu_NaN_flag, fpu_underflow_flag, fpu_overflow_flag};
          state_d     = S_ACK;
`ifdef FPU_DISPATCH_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          // TIMEOUT cycles spent in WAIT; ACK still drains a late ready
          res_data_d  = '0;
          res_flags_d = 4'b1000;
          state_d     = S_ACK;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      S_ACK: begin
        if (!fpu_operation_ready) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered FPU/result outputs; all cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rg_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rg_q        <= rg_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

`ifdef FPU_DISPATCH_TIMEOUT_EN
  // Cycle counter for the wait on fpu_operation_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign fpu_begin_operation = (state_q == S_WAIT);
  assign fpu_ack_operation   = (state_q == S_ACK);
  assign res_valid           = (state_q == S_OUT);
  assign fpu_operation       = op_q;
  assign fpu_region_flag     = rg_q;
  assign fpu_data_1          = d1_q;
  assign fpu_data_2          = d2_q;
  assign fpu_r_mode          = r_mode_in;
  assign res_data            = res_data_q;
`ifdef FPU_DISPATCH_TIMEOUT_EN
  assign res_flags           = res_flags_q;
`else
  assign res_flags           = {1'b0, res_flags_q[2:0]};
`endif

endmodule
